irrigation_zone_ctrl: RTL

Multi-zone successor to the single-sensor irrigation FSM. Drives one shared pump and N_ZONES zone valves from per-zone soil-moisture sensors. Uses hysteresis thresholds, timed watering/rest bursts, round-robin arbitration so only one zone waters at a time, and a per-zone dry-fault after repeated unsuccessful bursts. Sits between the sensor sampling front-end and the pump/valve drivers.

---
 rtl/irrigation_zone_ctrl.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/irrigation_zone_ctrl.sv
// Multi-zone irrigation controller: per-zone hysteresis FSMs with timed water/rest
// bursts, a shared pump granted round-robin to one zone at a time, and dry-fault latch.
module irrigation_zone #(
  parameter int SENSOR_W    = 8,
  parameter int LOW_TH      = 64,
  parameter int HIGH_TH     = 96,
  parameter int ON_CYCLES   = 20,
  parameter int REST_CYCLES = 20,
  parameter int MAX_BURSTS  = 3,
  parameter int CNT_W       = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [SENSOR_W-1:0] reading,
  input  logic                grant,
  input  logic                fault_clr,
  output logic                req,
  output logic                water,
  output logic                fault,
  output logic                active
);
  localparam int BW = (MAX_BURSTS > 1) ? $clog2(MAX_BURSTS + 1) : 1;

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WATER, S_REST, S_FAULT} state_t;

  state_t           state;
  logic [CNT_W-1:0] timer;
  logic [BW-1:0]    bursts;
  logic             dry, wet;

  assign dry    = int'(reading) < LOW_TH;
  assign wet    = int'(reading) >= HIGH_TH;
  // Only a request that will actually take the grant this edge competes for the pump.
  assign req    = (state == S_REQ) && enable && !wet;
  assign water  = (state == S_WATER);
  assign fault  = (state == S_FAULT);
  assign active = (state == S_REQ) || (state == S_WATER) || (state == S_REST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      timer  <= '0;
      bursts <= '0;
    end else begin
      case (state)
        S_IDLE:
          if (enable && dry) state <= S_REQ;
        S_REQ:
          if (!enable || wet) state <= S_IDLE;
          else if (grant) begin
            state <= S_WATER;
            timer <= CNT_W'(ON_CYCLES);
          end
        S_WATER:
          if (!enable) state <= S_IDLE;
          else if (wet) begin
            state  <= S_IDLE;
            bursts <= '0;
          end else if (timer == CNT_W'(1)) begin
            if (int'(bursts) + 1 == MAX_BURSTS) state <= S_FAULT;
            else begin
              state  <= S_REST;
              bursts <= bursts + 1'b1;
              timer  <= CNT_W'(REST_CYCLES);
            end
          end else timer <= timer - 1'b1;
        S_REST:
          if (wet) begin
            state  <= S_IDLE;
            bursts <= '0;
          end else if (timer == CNT_W'(1)) state <= enable ? S_REQ : S_IDLE;
          else timer <= timer - 1'b1;
        S_FAULT:
          if (fault_clr) begin
            state  <= S_IDLE;
            bursts <= '0;
          end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

module irrigation_zone_ctrl #(
  parameter int N_ZONES     = 4,
  parameter int SENSOR_W    = 8,
  parameter int LOW_TH      = 64,
  parameter int HIGH_TH     = 96,
  parameter int ON_CYCLES   = 20,
  parameter int REST_CYCLES = 20,
  parameter int MAX_BURSTS  = 3,
  parameter int CNT_W       = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic [N_ZONES*SENSOR_W-1:0] sensor,
  input  logic [N_ZONES-1:0]          fault_clr,
  output logic [N_ZONES-1:0]          valve,
  output logic                        pump,
  output logic [N_ZONES-1:0]          zone_fault,
  output logic                        busy
);
  localparam int PTR_W = (N_ZONES > 1) ? $clog2(N_ZONES) : 1;

  logic [N_ZONES-1:0] req_v, water_v, active_v, grant;
  logic [PTR_W-1:0]   ptr, gnt_idx;
  logic               gnt_found;

  for (genvar i = 0; i < N_ZONES; i++) begin : g_zone
    irrigation_zone #(
      .SENSOR_W(SENSOR_W), .LOW_TH(LOW_TH), .HIGH_TH(HIGH_TH),
      .ON_CYCLES(ON_CYCLES), .REST_CYCLES(REST_CYCLES),
      .MAX_BURSTS(MAX_BURSTS), .CNT_W(CNT_W)
    ) u_zone (
      .clk      (clk),
      .reset    (reset),
      .enable   (enable),
      .reading  (sensor[i*SENSOR_W +: SENSOR_W]),
      .grant    (grant[i]),
      .fault_clr(fault_clr[i]),
      .req      (req_v[i]),
      .water    (water_v[i]),
      .fault    (zone_fault[i]),
      .active   (active_v[i])
    );
  end

  assign valve = water_v;
  assign pump  = |water_v;
  assign busy  = |active_v;

  // No grant while any zone holds the pump: forces a one-cycle gap between zones.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    grant     = '0;
    if (!(|water_v)) begin
      for (int j = 0; j < N_ZONES; j++) begin
        if (!gnt_found && req_v[(int'(ptr) + j) % N_ZONES]) begin
          gnt_found = 1'b1;
          gnt_idx   = PTR_W'((int'(ptr) + j) % N_ZONES);
        end
      end
    end
    grant[gnt_idx] = gnt_found;
  end

  always_ff @(posedge clk) begin
    if (reset) ptr <= '0;
    else if (gnt_found)
      ptr <= (int'(gnt_idx) == N_ZONES - 1) ? '0 : gnt_idx + 1'b1;
  end
endmodule
